shift_counter_n: RTL

- Parametrised successor to the 4-bit ring/Johnson counter with 7-segment readout.
- Provides a WIDTH-bit counter with these features:
  - ring, Johnson, binary and hold modes
  - selectable direction, count enable and synchronous parallel load
  - a period-wrap pulse
  - a time-multiplexed multi-digit hex 7-segment display driver
- All state is on the rising clk edge, with no mixed-edge logic.
- Intended as the board-level counter/display block for lab designs.

---
 rtl/shift_counter_n.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/shift_counter_n.sv
// Parametrised ring/Johnson/binary counter with period-wrap pulse and a
// time-multiplexed hex 7-segment display driver.
module shift_counter_n #(
    parameter int WIDTH       = 8,
    parameter int SCAN_DIV    = 1000,
    parameter int RESET_VALUE = 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      en,
    input  logic [1:0]                mode,
    input  logic                      dir,
    input  logic                      lo,
    input  logic [WIDTH-1:0]          load,
    output logic [WIDTH-1:0]          q,
    output logic                      wrap,
    output logic [6:0]                seg,
    output logic [(WIDTH+3)/4-1:0]    an
);

    localparam int DIGITS = (WIDTH + 3) / 4;
    localparam int SW     = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int DW     = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [SW-1:0]     SCAN_LAST = SW'(SCAN_DIV - 1);
    localparam logic [DW-1:0]     DIG_LAST  = DW'(DIGITS - 1);
    localparam logic [WIDTH-1:0]  RST_Q     = WIDTH'(RESET_VALUE);
    localparam logic [3:0]        RST_NIB   = 4'(RESET_VALUE);
    localparam logic [DIGITS-1:0] AN_RST    = ~(DIGITS'(1));

    localparam logic [1:0] M_RING = 2'b00;
    localparam logic [1:0] M_JOHN = 2'b01;
    localparam logic [1:0] M_BIN  = 2'b10;
    localparam logic [1:0] M_HOLD = 2'b11;

    function automatic logic [6:0] decode(input logic [3:0] n);
        case (n)
            4'h0: decode = 7'b1000000;
            4'h1: decode = 7'b1111001;
            4'h2: decode = 7'b0100100;
            4'h3: decode = 7'b0110000;
            4'h4: decode = 7'b0011001;
            4'h5: decode = 7'b0010010;
            4'h6: decode = 7'b0000010;
            4'h7: decode = 7'b1111000;
            4'h8: decode = 7'b0000000;
            4'h9: decode = 7'b0011000;
            4'hA: decode = 7'b0001000;
            4'hB: decode = 7'b0000011;
            4'hC: decode = 7'b1000110;
            4'hD: decode = 7'b0100001;
            4'hE: decode = 7'b0000110;
            default: decode = 7'b0001110;
        endcase
    endfunction

    logic [WIDTH-1:0]    cnt;
    logic [WIDTH-1:0]    cnt_base;
    logic [WIDTH-1:0]    q_next;
    logic [WIDTH:0]      period;
    logic [WIDTH:0]      cnt_inc;
    logic [1:0]          mode_q;
    logic                step;
    logic [SW-1:0]       scan;
    logic [DW-1:0]       dig;
    logic [DW-1:0]       dig_next;
    logic [DIGITS-1:0]   an_next;
    logic [4*DIGITS-1:0] q_pad;
    logic [3:0]          nib;

    always_comb begin
        q_next = q;
        period = '0;
        case (mode)
            M_RING: begin
                q_next = dir ? {q[0], q[WIDTH-1:1]} : {q[WIDTH-2:0], q[WIDTH-1]};
                period = (WIDTH+1)'(WIDTH);
            end
            M_JOHN: begin
                q_next = dir ? {~q[0], q[WIDTH-1:1]} : {q[WIDTH-2:0], ~q[WIDTH-1]};
                period = (WIDTH+1)'(2 * WIDTH);
            end
            M_BIN: begin
                q_next = dir ? q - WIDTH'(1) : q + WIDTH'(1);
                period = (WIDTH+1)'(1) << WIDTH;
            end
            default: begin
                q_next = q;
                period = '0;
            end
        endcase
        step     = en && (mode != M_HOLD);
        // A mode change restarts the period count; the step on that edge counts.
        cnt_base = (mode != mode_q) ? '0 : cnt;
        cnt_inc  = {1'b0, cnt_base} + (WIDTH+1)'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q      <= RST_Q;
            cnt    <= '0;
            wrap   <= 1'b0;
            mode_q <= M_RING;
        end else begin
            mode_q <= mode;
            wrap   <= 1'b0;
            if (lo) begin
                q   <= load;
                cnt <= '0;
            end else if (step) begin
                q <= q_next;
                if (cnt_inc == period) begin
                    cnt  <= '0;
                    wrap <= 1'b1;
                end else begin
                    cnt <= cnt_inc[WIDTH-1:0];
                end
            end else begin
                cnt <= cnt_base;
            end
        end
    end

    always_comb begin
        dig_next = dig;
        if (scan == SCAN_LAST)
            dig_next = (dig == DIG_LAST) ? '0 : dig + DW'(1);
        an_next           = '1;
        an_next[dig_next] = 1'b0;
        q_pad             = (4*DIGITS)'(q);
        nib               = q_pad[{dig, 2'b00} +: 4];
    end

    // an follows the new digit index at once; seg decodes the current q for the
    // digit that was active, so it trails both q and an by one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scan <= '0;
            dig  <= '0;
            an   <= AN_RST;
            seg  <= decode(RST_NIB);
        end else begin
            scan <= (scan == SCAN_LAST) ? '0 : scan + SW'(1);
            dig  <= dig_next;
            an   <= an_next;
            seg  <= decode(nib);
        end
    end

endmodule
